// File: rtl/program_builder.sv
// program_builder: encodes operator fields into instruction words and stores them in program RAM
module program_builder #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter logic [7:0] NOP_WORD = 8'hF0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        op,
  input  logic [1:0]        dst,
  input  logic [1:0]        src,
  input  logic              wr_pulse,
  input  logic              undo_pulse,
  input  logic              clear_pulse,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              busy,
  output logic [7:0]        last_word,
  output logic              err
);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] sweep, sweep_n, wa, top, prev;
  logic [ADDR_W:0] count_n;
  logic [7:0] last_n, word, wd;
  logic [7:0] mem [DEPTH];
  logic [7:0] shadow [DEPTH];
  logic err_n, we, bad, forced;
  assign forced = op == 4'b1001 || op == 4'b1010 || op == 4'b1011;
  assign word = {op, dst, forced ? 2'b00 : src};
  assign bad = op[3:2] == 2'b11 || ((op == 4'b1000 || op == 4'b1011) && dst[1]);
  assign top = count[ADDR_W-1:0] - ADDR_W'(1);
  assign prev = count[ADDR_W-1:0] - ADDR_W'(2);
  assign full = count == (ADDR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign busy = state == CLEAR;
  // next-state, RAM write request and bookkeeping for each strobe, clear > undo > write
  always_comb begin
    state_n = state;
    sweep_n = sweep;
    count_n = count;
    last_n = last_word;
    err_n = 1'b0;
    we = 1'b0;
    wa = sweep;
    wd = NOP_WORD;
    if (state == CLEAR) begin
      we = 1'b1;
      sweep_n = sweep + ADDR_W'(1);
      state_n = sweep == ADDR_W'(DEPTH - 1) ? IDLE : CLEAR;
      err_n = wr_pulse | undo_pulse | clear_pulse;
    end else if (clear_pulse) begin
      state_n = CLEAR;
      sweep_n = '0;
      count_n = '0;
      last_n = NOP_WORD;
    end else if (undo_pulse) begin
      if (empty) err_n = 1'b1;
      else begin
        we = 1'b1;
        wa = top;
        count_n = count - (ADDR_W+1)'(1);
        last_n = count == (ADDR_W+1)'(1) ? NOP_WORD : shadow[prev];
      end
    end else if (wr_pulse) begin
      if (bad || full) err_n = 1'b1;
      else begin
        we = 1'b1;
        wa = count[ADDR_W-1:0];
        wd = word;
        count_n = count + (ADDR_W+1)'(1);
        last_n = word;
      end
    end
  end
  // control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      sweep <= '0;
      count <= '0;
      last_word <= NOP_WORD;
      err <= 1'b0;
    end else begin
      state <= state_n;
      sweep <= sweep_n;
      count <= count_n;
      last_word <= last_n;
      err <= err_n;
    end
  end
  // program RAM with registered read-before-write port, plus shadow copy for undo lookback
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem[wa] <= wd;
      shadow[wa] <= wd;
    end
    rd_data <= reset ? NOP_WORD : mem[rd_addr];
  end
endmodule

// File: tb/tb_program_builder.sv
// tb_program_builder: directed plus random checks of program_builder against a queue model
module tb_program_builder;
  localparam logic [7:0] NOP = 8'hF0;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] op = '0;
  logic [1:0] dst = '0, src = '0;
  logic wr = 1'b0, undo = 1'b0, clr = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data, last_word;
  logic [4:0] count;
  logic full, empty, busy, err;
  int total = 0, passed = 0, mb = 16, n;
  logic [7:0] q[$];
  logic [3:0] o;
  logic [1:0] d, s;

  program_builder dut (
    .clk(clk), .reset(reset), .op(op), .dst(dst), .src(src),
    .wr_pulse(wr), .undo_pulse(undo), .clear_pulse(clr), .rd_addr(rd_addr),
    .rd_data(rd_data), .count(count), .full(full), .empty(empty),
    .busy(busy), .last_word(last_word), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] mem_at(input int i);
    return i < q.size() ? q[i] : NOP;
  endfunction

  task automatic step(input bit w, u, c, input logic [3:0] ov, input logic [1:0] dv, sv,
                      input logic [3:0] ra);
    logic exp_err;
    logic [7:0] exp_rd;
    bit chk_rd;
    op = ov; dst = dv; src = sv; wr = w; undo = u; clr = c; rd_addr = ra;
    chk_rd = mb == 0;
    exp_rd = mem_at(int'(ra));
    exp_err = 1'b0;
    if (mb > 0) begin
      exp_err = w | u | c;
      mb--;
    end else if (c) begin
      q.delete();
      mb = 16;
    end else if (u) begin
      if (q.size() == 0) exp_err = 1'b1;
      else void'(q.pop_back());
    end else if (w) begin
      if (ov >= 12 || ((ov == 8 || ov == 11) && dv >= 2) || q.size() == 16) exp_err = 1'b1;
      else q.push_back({ov, dv, (ov >= 9 && ov <= 11) ? 2'b00 : sv});
    end
    @(negedge clk);
    wr = 1'b0; undo = 1'b0; clr = 1'b0;
    chk("err", 32'(err), 32'(exp_err));
    chk("count", 32'(count), 32'(q.size()));
    chk("last_word", 32'(last_word), 32'(q.size() > 0 ? q[$] : NOP));
    chk("busy", 32'(busy), 32'(mb > 0));
    chk("full", 32'(full), 32'(q.size() == 16));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    if (chk_rd) chk("rd_data", 32'(rd_data), 32'(exp_rd));
  endtask

  task automatic idle(input logic [3:0] ra);
    step(0, 0, 0, 4'd0, 2'd0, 2'd0, ra);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    q.delete();
    mb = 16;
    repeat (cycles) @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_last", 32'(last_word), 32'(NOP));
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rd", 32'(rd_data), 32'(NOP));
    reset = 1'b0;
  endtask

  task automatic busy_len(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      idle(4'($urandom_range(15)));
      cnt++;
    end
  endtask

  task automatic rand_valid(output logic [3:0] ov, output logic [1:0] dv, sv);
    ov = 4'($urandom_range(11));
    dv = (ov == 8 || ov == 11) ? 2'($urandom_range(1)) : 2'($urandom_range(3));
    sv = 2'($urandom_range(3));
  endtask

  initial begin
    do_reset(2);
    busy_len(n);
    chk("busy_len_reset", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) idle(4'(i));

    step(1, 0, 0, 4'b0010, 2'b00, 2'b01, 4'd0);
    step(1, 0, 0, 4'b1001, 2'b01, 2'b11, 4'd0);
    chk("last_94", 32'(last_word), 32'h94);
    idle(4'd0);
    chk("mem0_21", 32'(rd_data), 32'h21);
    idle(4'd1);
    chk("mem1_94", 32'(rd_data), 32'h94);

    step(0, 0, 1, 4'd0, 2'd0, 2'd0, 4'd0);
    busy_len(n);
    chk("busy_len_clear", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) begin
      rand_valid(o, d, s);
      step(1, 0, 0, o, d, s, 4'(i));
    end
    step(1, 0, 0, 4'b0001, 2'b00, 2'b00, 4'd15);
    chk("err_full", 32'(err), 32'd1);
    chk("count_full", 32'(count), 32'd16);
    idle(4'd15);

    step(0, 0, 1, 4'd0, 2'd0, 2'd0, 4'd0);
    busy_len(n);
    step(1, 0, 0, 4'b0000, 2'b00, 2'b01, 4'd0);
    step(1, 0, 0, 4'b0001, 2'b00, 2'b10, 4'd0);
    step(1, 0, 0, 4'b0010, 2'b01, 2'b00, 4'd0);
    step(0, 1, 0, 4'd0, 2'd0, 2'd0, 4'd2);
    chk("undo_last_12", 32'(last_word), 32'h12);
    chk("undo_count_2", 32'(count), 32'd2);
    idle(4'd2);
    chk("undo_mem2_nop", 32'(rd_data), 32'(NOP));
    step(0, 1, 0, 4'd0, 2'd0, 2'd0, 4'd0);
    step(0, 1, 0, 4'd0, 2'd0, 2'd0, 4'd0);
    chk("undo_empty", 32'(empty), 32'd1);
    step(0, 1, 0, 4'd0, 2'd0, 2'd0, 4'd0);
    chk("undo_err", 32'(err), 32'd1);

    step(1, 0, 0, 4'b1101, 2'b00, 2'b00, 4'd0);
    step(1, 0, 0, 4'b1011, 2'b10, 2'b00, 4'd0);
    step(1, 0, 0, 4'b0011, 2'b01, 2'b01, 4'd0);
    step(1, 1, 1, 4'b0011, 2'b01, 2'b01, 4'd0);
    chk("prio_busy", 32'(busy), 32'd1);
    chk("prio_err", 32'(err), 32'd0);

    step(1, 0, 0, 4'b0011, 2'b01, 2'b01, 4'd0);
    chk("busy_wr_err", 32'(err), 32'd1);
    repeat (6) idle(4'd0);
    do_reset(1);
    busy_len(n);
    chk("busy_len_midreset", 32'(n), 32'd16);

    for (int i = 0; i < 600; i++) begin
      o = 4'($urandom_range(15));
      d = 2'($urandom_range(3));
      s = 2'($urandom_range(3));
      step($urandom_range(99) < 55, $urandom_range(99) < 25, $urandom_range(99) < 3,
           o, d, s, 4'($urandom_range(15)));
    end
    busy_len(n);
    for (int i = 0; i < 16; i++) idle(4'(i));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
